// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between requesters and the weighted round-robin arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface wrr_arbiter_if #(
    parameter int CLIENTS  = 32,
    parameter int WEIGHT_W = 4,
    parameter int IDX_W    = $clog2(CLIENTS)
);
    logic [CLIENTS-1:0]          request;
    logic [CLIENTS*WEIGHT_W-1:0] weight;
    logic                        stall;
    logic [CLIENTS-1:0]          grant;
    logic                        grant_valid;
    logic [IDX_W-1:0]            grant_id;

    modport master (
        output request, weight, stall,
        input  grant, grant_valid, grant_id
    );

    modport slave (
        input  request, weight, stall,
        output grant, grant_valid, grant_id
    );
endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant, bursts of weight+1 cycles,
// rotating priority pointer and a stall input that freezes all arbitration state.
module wrr_arbiter #(
    parameter int CLIENTS  = 32,
    parameter int WEIGHT_W = 4,
    parameter int IDX_W    = $clog2(CLIENTS)
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    wrr_arbiter_if.slave arb_if
);
    localparam int CW = IDX_W + 1;

    logic [CLIENTS-1:0]  r_grant;
    logic                r_grant_valid;
    logic [IDX_W-1:0]    r_grant_id;
    logic [IDX_W-1:0]    r_ptr;
    logic [WEIGHT_W-1:0] r_burst_cnt;
    logic [WEIGHT_W-1:0] r_burst_lim;

    logic [CLIENTS-1:0]  w_grant_next;
    logic                w_grant_valid_next;
    logic [IDX_W-1:0]    w_grant_id_next;
    logic [IDX_W-1:0]    w_ptr_next;
    logic [WEIGHT_W-1:0] w_burst_cnt_next;
    logic [WEIGHT_W-1:0] w_burst_lim_next;

    logic [WEIGHT_W-1:0] w_weight [CLIENTS];
    logic                w_found;
    logic [IDX_W-1:0]    w_winner;
    logic [CW-1:0]       w_cand;
    logic                w_continue;

    generate
        for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_weight
            assign w_weight[gi] = arb_if.weight[gi*WEIGHT_W +: WEIGHT_W];
        end
    endgenerate

    // Circular scan starting at r_ptr; the previous grantee sits at r_ptr-1, so it is seen last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 0; k < CLIENTS; k++) begin
            w_cand = {1'b0, r_ptr} + CW'(k);
            if (w_cand >= CW'(CLIENTS)) begin
                w_cand = w_cand - CW'(CLIENTS);
            end
            if (!w_found && arb_if.request[w_cand[IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[IDX_W-1:0];
            end
        end
    end

    assign w_continue = r_grant_valid && arb_if.request[r_grant_id]
                        && (r_burst_cnt < r_burst_lim);

    always_comb begin
        w_grant_next       = r_grant;
        w_grant_valid_next = r_grant_valid;
        w_grant_id_next    = r_grant_id;
        w_ptr_next         = r_ptr;
        w_burst_cnt_next   = r_burst_cnt;
        w_burst_lim_next   = r_burst_lim;
        if (!arb_if.stall) begin
            if (w_continue) begin
                w_burst_cnt_next = r_burst_cnt + WEIGHT_W'(1);
            end else if (w_found) begin
                w_grant_next           = '0;
                w_grant_next[w_winner] = 1'b1;
                w_grant_valid_next     = 1'b1;
                w_grant_id_next        = w_winner;
                w_burst_cnt_next       = '0;
                // Burst length is fixed here; later weight changes only affect the next burst.
                w_burst_lim_next       = w_weight[w_winner];
                w_ptr_next             = (w_winner == IDX_W'(CLIENTS - 1)) ? '0
                                         : w_winner + IDX_W'(1);
            end else begin
                w_grant_next       = '0;
                w_grant_valid_next = 1'b0;
                w_grant_id_next    = '0;
                w_burst_cnt_next   = '0;
                w_burst_lim_next   = '0;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_ptr         <= '0;
            r_burst_cnt   <= '0;
            r_burst_lim   <= '0;
        end else begin
            r_grant       <= w_grant_next;
            r_grant_valid <= w_grant_valid_next;
            r_grant_id    <= w_grant_id_next;
            r_ptr         <= w_ptr_next;
            r_burst_cnt   <= w_burst_cnt_next;
            r_burst_lim   <= w_burst_lim_next;
        end
    end

    assign arb_if.grant       = r_grant;
    assign arb_if.grant_valid = r_grant_valid;
    assign arb_if.grant_id    = r_grant_id;
endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter: idle, rotation, bursts, early drop, stall and async reset.
module tb_wrr_arbiter;
    localparam int CLIENTS  = 32;
    localparam int WEIGHT_W = 4;
    localparam int IDX_W    = $clog2(CLIENTS);

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    wrr_arbiter_if #(.CLIENTS(CLIENTS), .WEIGHT_W(WEIGHT_W), .IDX_W(IDX_W)) bus ();

    wrr_arbiter #(.CLIENTS(CLIENTS), .WEIGHT_W(WEIGHT_W), .IDX_W(IDX_W)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .arb_if    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h required=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input int id);
        logic [CLIENTS-1:0] exp_vec;
        exp_vec = '0;
        exp_vec[id] = 1'b1;
        $display("t=%0t %s grant_id=%0d (expect %0d)", $time, tag, bus.grant_id, id);
        check_eq({tag, "_grant"}, 64'(bus.grant), 64'(exp_vec));
        check_eq({tag, "_valid"}, 64'(bus.grant_valid), 64'd1);
        check_eq({tag, "_id"}, 64'(bus.grant_id), 64'(id));
    endtask

    task automatic expect_idle(input string tag);
        $display("t=%0t %s idle grant=0x%0h", $time, tag, bus.grant);
        check_eq({tag, "_grant"}, 64'(bus.grant), 64'd0);
        check_eq({tag, "_valid"}, 64'(bus.grant_valid), 64'd0);
        check_eq({tag, "_id"}, 64'(bus.grant_id), 64'd0);
    endtask

    task automatic set_weight(input int client, input int w);
        bus.weight[client*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(w);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.request = '0;
        bus.weight  = '0;
        bus.stall   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset state and idle
        rst_n       = 1'b0;
        bus.request = '0;
        bus.weight  = '0;
        bus.stall   = 1'b0;
        #3;
        expect_idle("reset");
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick();
            expect_idle("idle");
        end

        // Plain rotation with all weights zero
        do_reset();
        bus.request = '1;
        for (int k = 0; k <= CLIENTS; k++) begin
            tick();
            expect_grant("rot", k % CLIENTS);
        end

        // Burst of weight+1 cycles, then neighbour, then back
        do_reset();
        set_weight(4, 3);
        bus.request[4] = 1'b1;
        bus.request[5] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_grant("burst4", 4);
        end
        tick();
        expect_grant("burst5", 5);
        tick();
        expect_grant("burst4_again", 4);

        // Early drop ends the burst at the next edge
        do_reset();
        set_weight(2, 7);
        bus.request[2] = 1'b1;
        bus.request[6] = 1'b1;
        tick();
        expect_grant("drop_g2a", 2);
        tick();
        expect_grant("drop_g2b", 2);
        bus.request[2] = 1'b0;
        tick();
        expect_grant("drop_g6", 6);
        tick();
        expect_grant("drop_g6_again", 6);

        // Stall mid-burst freezes grant and burst count
        do_reset();
        set_weight(7, 3);
        bus.request[7] = 1'b1;
        bus.request[8] = 1'b1;
        tick();
        expect_grant("stall_pre0", 7);
        tick();
        expect_grant("stall_pre1", 7);
        bus.stall = 1'b1;
        bus.request[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            expect_grant("stall_hold", 7);
        end
        bus.stall = 1'b0;
        tick();
        expect_grant("stall_post2", 7);
        tick();
        expect_grant("stall_post3", 7);
        tick();
        expect_grant("stall_next8", 8);

        // Stall with a new request while idle: request waits
        do_reset();
        bus.stall = 1'b1;
        bus.request[3] = 1'b1;
        tick();
        expect_idle("stall_idle");
        tick();
        expect_idle("stall_idle2");
        bus.stall = 1'b0;
        tick();
        expect_grant("stall_release", 3);

        // Asynchronous reset mid-burst; pointer restarts at 0
        do_reset();
        set_weight(9, 5);
        bus.request[9] = 1'b1;
        tick();
        expect_grant("rst_burst0", 9);
        tick();
        expect_grant("rst_burst1", 9);
        #2;
        rst_n = 1'b0;
        #1;
        expect_idle("rst_async");
        tick();
        expect_idle("rst_held");
        bus.request[3] = 1'b1;
        #2;
        rst_n = 1'b1;
        tick();
        expect_grant("rst_after3", 3);
        tick();
        expect_grant("rst_after9", 9);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
